// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor: power-down, reset hold, lock wait and
// stability qualification, with retry accounting and a registered system reset.
module pll_lock_supervisor #(
  parameter int PWD_CYCLES    = 16,
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 4096,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart_req,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic       rstodiv,
  output logic       sys_rst,
  output logic       locked_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_PWD    = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STABLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam logic [CNT_W-1:0] PWD_LOAD    = CNT_W'(PWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

  logic [1:0]       sync_reg;
  logic             lock_s;
  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       retry_reg, retry_next, retry_inc;
  logic             attempt_fail;
  logic             pll_pwd_next, pll_rst_next, rstodiv_next;
  logic             sys_rst_next, locked_ok_next, fail_next;

  // Two-flop synchronizer for the raw lock, which is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], pll_lock};
    end
  end

  assign lock_s = sync_reg[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_PWD;
      cnt_reg   <= PWD_LOAD;
      retry_reg <= 4'd0;
      pll_pwd   <= 1'b1;
      pll_rst   <= 1'b1;
      rstodiv   <= 1'b1;
      sys_rst   <= 1'b1;
      locked_ok <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      pll_pwd   <= pll_pwd_next;
      pll_rst   <= pll_rst_next;
      rstodiv   <= rstodiv_next;
      sys_rst   <= sys_rst_next;
      locked_ok <= locked_ok_next;
      fail      <= fail_next;
    end
  end

  assign retry_inc = (retry_reg == 4'hF) ? 4'hF : retry_reg + 4'd1;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = (cnt_reg == '0) ? cnt_reg : cnt_reg - CNT_ONE;
    retry_next   = retry_reg;
    attempt_fail = 1'b0;
    if (restart_req) begin
      state_next = S_PWD;
      cnt_next   = PWD_LOAD;
      retry_next = 4'd0;
    end else begin
      case (state_reg)
        S_PWD: begin
          if (cnt_reg == '0) begin
            state_next = S_RST;
            cnt_next   = RST_LOAD;
          end
        end
        S_RST: begin
          if (cnt_reg == '0) begin
            state_next = S_WAIT;
            cnt_next   = TO_LOAD;
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state_next = S_STABLE;
            cnt_next   = STABLE_LOAD;
          end else if (cnt_reg == '0) begin
            attempt_fail = 1'b1;
          end
        end
        S_STABLE: begin
          // Any single low cycle of lock_s disqualifies the attempt.
          if (!lock_s) begin
            attempt_fail = 1'b1;
          end else if (cnt_reg == '0) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_next = S_PWD;
            cnt_next   = PWD_LOAD;
          end
        end
        S_FAIL: begin
          state_next = S_FAIL;
        end
        default: begin
          state_next = S_PWD;
          cnt_next   = PWD_LOAD;
        end
      endcase
      if (attempt_fail) begin
        retry_next = retry_inc;
        if (retry_inc > MAX_R) begin
          state_next = S_FAIL;
          cnt_next   = '0;
        end else begin
          state_next = S_PWD;
          cnt_next   = PWD_LOAD;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they move together with state_o.
  always_comb begin
    pll_pwd_next   = (state_next == S_PWD) || (state_next == S_FAIL);
    pll_rst_next   = (state_next == S_PWD) || (state_next == S_RST) || (state_next == S_FAIL);
    rstodiv_next   = (state_next == S_PWD) || (state_next == S_RST) || (state_next == S_WAIT) ||
                     (state_next == S_FAIL);
    sys_rst_next   = (state_next != S_RUN);
    locked_ok_next = (state_next == S_RUN);
    fail_next      = (state_next == S_FAIL);
  end

  assign retry_cnt = retry_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random
// lock/restart stimulus compared against a dwell-time based reference model.
module tb_pll_lock_supervisor;
  localparam int PWD_C  = 4;
  localparam int RST_C  = 8;
  localparam int TO_C   = 100;
  localparam int STAB_C = 16;
  localparam int MAXR   = 2;
  localparam logic [12:0] RESET_VEC = 13'b1111_0_0_0000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_pwd, pll_rst, rstodiv, sys_rst, locked_ok, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;
  logic [12:0] dut_vec;
  int tests = 0;
  int fails = 0;

  pll_lock_supervisor #(
    .PWD_CYCLES(PWD_C), .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C),
    .STABLE_CYCLES(STAB_C), .MAX_RETRIES(MAXR), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .restart_req(restart_req),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .rstodiv(rstodiv), .sys_rst(sys_rst),
    .locked_ok(locked_ok), .fail(fail), .retry_cnt(retry_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pll_pwd, pll_rst, rstodiv, sys_rst, locked_ok, fail, retry_cnt, state_o};

  // Reference model: state name, cycles spent in it so far, failed-attempt count.
  int m_state = 0;
  int m_age = 0;
  int m_retry = 0;
  bit [1:0] m_hist = 2'b00;  // pll_lock as seen one and two edges ago
  int mn_state, mn_age, mn_retry;
  bit m_bad;

  always_comb begin
    mn_state = m_state;
    mn_retry = m_retry;
    m_bad = 1'b0;
    if (restart_req) begin
      mn_state = 0;
      mn_retry = 0;
    end else begin
      case (m_state)
        0: if (m_age + 1 >= PWD_C) mn_state = 1;
        1: if (m_age + 1 >= RST_C) mn_state = 2;
        2: if (m_hist[1]) mn_state = 3; else if (m_age + 1 >= TO_C) m_bad = 1'b1;
        3: if (!m_hist[1]) m_bad = 1'b1; else if (m_age + 1 >= STAB_C) mn_state = 4;
        4: if (!m_hist[1]) mn_state = 0;
        default: mn_state = m_state;
      endcase
      if (m_bad) begin
        mn_retry = (m_retry < 15) ? m_retry + 1 : 15;
        mn_state = (mn_retry > MAXR) ? 5 : 0;
      end
    end
    mn_age = (restart_req || mn_state != m_state) ? 0 : m_age + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_age   <= 0;
      m_retry <= 0;
      m_hist  <= 2'b00;
    end else begin
      m_state <= mn_state;
      m_age   <= mn_age;
      m_retry <= mn_retry;
      m_hist  <= {m_hist[0], pll_lock};
    end
  end

  function automatic logic [12:0] exp_vec();
    logic [2:0] s;
    s = 3'(m_state);
    return {(m_state == 0 || m_state == 5), (m_state <= 1 || m_state == 5),
            (m_state <= 2 || m_state == 5), (m_state != 4), (m_state == 4),
            (m_state == 5), 4'(m_retry), s};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic lock_lvl);
    @(negedge clk);
    rst = 1'b1;
    restart_req = 1'b0;
    pll_lock = lock_lvl;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (dut_vec !== RESET_VEC) begin
      fails++;
      $display("FAIL reset_outputs got=%b exp=%b", dut_vec, RESET_VEC);
    end
    tests++;
    if (dut_vec !== exp_vec()) begin
      fails++;
      $display("FAIL reset_model got=%b exp=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_nominal();
    int pwd_n = 0, prst_n = 0, mism = 0;
    int t_fall = -1, t_lock = -1, t_stable = -1, t_run = -1;
    rst = 1'b0;
    for (int idx = 0; idx < 300 && t_run < 0; idx++) begin
      if (idx > 0) step();
      if (dut_vec !== exp_vec()) mism++;
      if (pll_pwd) pwd_n++;
      if (pll_rst) prst_n++;
      if (!pll_rst && t_fall < 0) t_fall = idx;
      if (state_o == 3'd3 && t_stable < 0) t_stable = idx;
      if (!sys_rst && t_run < 0) t_run = idx;
      if (t_fall >= 0 && idx == t_fall + 20) begin
        pll_lock = 1'b1;
        t_lock = idx + 1;  // first clock edge that samples the new level
      end
    end
    tests++;
    if (t_run < 0) begin
      fails++;
      $display("FAIL nominal_timeout got=no_run exp=run_within_300");
    end
    tests++;
    if (pwd_n != PWD_C) begin fails++; $display("FAIL nominal_pwd_len got=%0d exp=%0d", pwd_n, PWD_C); end
    tests++;
    if (prst_n != PWD_C + RST_C) begin fails++; $display("FAIL nominal_rst_len got=%0d exp=%0d", prst_n, PWD_C + RST_C); end
    tests++;
    if (t_stable - t_lock != 2) begin fails++; $display("FAIL nominal_lock_latency got=%0d exp=2", t_stable - t_lock); end
    tests++;
    if (t_run - t_stable != STAB_C) begin fails++; $display("FAIL nominal_stable_len got=%0d exp=%0d", t_run - t_stable, STAB_C); end
    tests++;
    if (locked_ok !== 1'b1 || state_o !== 3'd4) begin
      fails++;
      $display("FAIL nominal_run got=ok%b/st%0d exp=ok1/st4", locked_ok, state_o);
    end
    tests++;
    if (mism != 0) begin fails++; $display("FAIL nominal_model got=%0d_mismatches exp=0", mism); end
  endtask

  task automatic test_run_loss();
    repeat (5) step();
    tests++;
    if (state_o !== 3'd4) begin fails++; $display("FAIL runloss_pre got=%0d exp=4", state_o); end
    pll_lock = 1'b0;
    step();
    step();
    tests++;
    if (state_o !== 3'd4 || sys_rst !== 1'b0) begin
      fails++;
      $display("FAIL runloss_early got=st%0d/sr%b exp=st4/sr0", state_o, sys_rst);
    end
    step();
    tests++;
    if (state_o !== 3'd0 || sys_rst !== 1'b1 || retry_cnt !== 4'd0) begin
      fails++;
      $display("FAIL runloss_drop got=st%0d/sr%b/rc%0d exp=st0/sr1/rc0", state_o, sys_rst, retry_cnt);
    end
    tests++;
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL runloss_model got=%b exp=%b", dut_vec, exp_vec()); end
  endtask

  task automatic test_timeout();
    int lens[$];
    int rts[$];
    int cur = 0, mism = 0, held_bad = 0;
    bit prev_wait = 1'b0;
    apply_reset(1'b0);
    for (int idx = 0; idx < 1000 && state_o != 3'd5; idx++) begin
      step();
      if (dut_vec !== exp_vec()) mism++;
      if (state_o == 3'd2) cur++;
      else if (prev_wait) begin
        lens.push_back(cur);
        rts.push_back(int'(retry_cnt));
        cur = 0;
      end
      prev_wait = (state_o == 3'd2);
    end
    tests++;
    if (lens.size() != 3) begin
      fails++;
      $display("FAIL timeout_attempts got=%0d exp=3", lens.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (lens[i] != TO_C || rts[i] != i + 1) begin
          fails++;
          $display("FAIL timeout_try%0d got=len%0d/rc%0d exp=len%0d/rc%0d", i, lens[i], rts[i], TO_C, i + 1);
        end
      end
    end
    repeat (60) begin
      step();
      if (state_o !== 3'd5 || fail !== 1'b1 || pll_pwd !== 1'b1 || sys_rst !== 1'b1) held_bad++;
    end
    tests++;
    if (held_bad != 0) begin fails++; $display("FAIL timeout_fail_hold got=%0d_bad_cycles exp=0", held_bad); end
    tests++;
    if (mism != 0) begin fails++; $display("FAIL timeout_model got=%0d_mismatches exp=0", mism); end
  endtask

  task automatic test_restart();
    int w = -1;
    restart_req = 1'b1;
    step();
    restart_req = 1'b0;
    tests++;
    if (state_o !== 3'd0 || fail !== 1'b0 || retry_cnt !== 4'd0) begin
      fails++;
      $display("FAIL restart_from_fail got=st%0d/f%b/rc%0d exp=st0/f0/rc0", state_o, fail, retry_cnt);
    end
    for (int idx = 0; idx < 50 && w < 0; idx++) begin
      step();
      if (state_o == 3'd2) w = idx;
    end
    repeat (TO_C - 1) step();
    tests++;
    if (state_o !== 3'd2) begin fails++; $display("FAIL restart_wait_end got=%0d exp=2", state_o); end
    restart_req = 1'b1;
    step();
    restart_req = 1'b0;
    tests++;
    if (state_o !== 3'd0 || fail !== 1'b0 || retry_cnt !== 4'd0) begin
      fails++;
      $display("FAIL restart_vs_timeout got=st%0d/f%b/rc%0d exp=st0/f0/rc0", state_o, fail, retry_cnt);
    end
    tests++;
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL restart_model got=%b exp=%b", dut_vec, exp_vec()); end
  endtask

  task automatic test_dropout();
    int found = 0, mism = 0;
    apply_reset(1'b1);
    for (int idx = 0; idx < 100 && found == 0; idx++) begin
      step();
      if (state_o == 3'd3) found = 1;
    end
    repeat (8) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    step();
    tests++;
    if (state_o !== 3'd3) begin fails++; $display("FAIL dropout_stable10 got=%0d exp=3", state_o); end
    step();
    tests++;
    if (state_o !== 3'd0 || retry_cnt !== 4'd1) begin
      fails++;
      $display("FAIL dropout_retry got=st%0d/rc%0d exp=st0/rc1", state_o, retry_cnt);
    end
    found = 0;
    for (int idx = 0; idx < 200 && found == 0; idx++) begin
      step();
      if (dut_vec !== exp_vec()) mism++;
      if (state_o == 3'd4) found = 1;
    end
    tests++;
    if (found == 0 || locked_ok !== 1'b1 || retry_cnt !== 4'd1) begin
      fails++;
      $display("FAIL dropout_recover got=st%0d/ok%b/rc%0d exp=st4/ok1/rc1", state_o, locked_ok, retry_cnt);
    end
    tests++;
    if (mism != 0) begin fails++; $display("FAIL dropout_model got=%0d_mismatches exp=0", mism); end
  endtask

  task automatic test_async_reset();
    int found = 0;
    apply_reset(1'b1);
    for (int idx = 0; idx < 100 && found == 0; idx++) begin
      step();
      if (state_o == 3'd3) found = 1;
    end
    repeat (3) step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (dut_vec !== RESET_VEC) begin
      fails++;
      $display("FAIL async_reset got=%b exp=%b", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int seg = 0, printed = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        pll_lock = ~pll_lock;
        seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 80);
      end
      seg--;
      restart_req = ($urandom_range(0, 199) == 0);
      step();
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        if (printed < 10) $display("FAIL random_c%0d got=%b exp=%b", c, dut_vec, exp_vec());
        printed++;
      end
    end
    restart_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_run_loss();
    test_timeout();
    test_restart();
    test_dropout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
